// File: rtl/tel_pkg.sv
// tel_pkg -- shared constants for the telephone line controller.
// State encoding, ASCII constants, status strings and the hex digit helper.
package tel_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RINGING  = 3'd1,
    S_CALLER   = 3'd2,
    S_CALLEE   = 3'd3,
    S_REJECTED = 3'd4,
    S_COST     = 3'd5
  } tel_state_e;

  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_DEL   = 8'h7F;
  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_9     = 8'h39;
  localparam logic [7:0] ASC_A     = 8'h41;
  localparam logic [7:0] ASC_TILDE = 8'h7E;

  localparam logic [63:0] STR_IDLE     = "IDLE    ";
  localparam logic [63:0] STR_RINGING  = "RINGING ";
  localparam logic [63:0] STR_CALLER   = "CALLER  ";
  localparam logic [63:0] STR_CALLEE   = "CALLEE  ";
  localparam logic [63:0] STR_REJECTED = "REJECTED";
  localparam logic [63:0] STR_COST     = "COST    ";

  // One nibble to its uppercase ASCII hex digit.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return ASC_0 + {4'b0000, n};
    else           return ASC_A + {4'b0000, n} - 8'd10;
  endfunction

endpackage

// File: rtl/tel_hex_fmt.sv
// tel_hex_fmt -- combinational cost-to-text formatter.
// Right-aligned uppercase hex; positions past COST_W/4 digits are spaces,
// and a short message keeps only the low digits.
module tel_hex_fmt
  import tel_pkg::*;
#(
  parameter int COST_W    = 32,
  parameter int MSG_CHARS = 8
) (
  input  logic [COST_W-1:0]      i_cost,
  output logic [8*MSG_CHARS-1:0] o_text
);

  for (genvar g = 0; g < MSG_CHARS; g++) begin : g_ch
    if (g < COST_W / 4) begin : g_dig
      assign o_text[8*g +: 8] = hex_char(i_cost[4*g +: 4]);
    end else begin : g_sp
      assign o_text[8*g +: 8] = ASC_SPACE;
    end
  end

endmodule

// File: rtl/tel_line_ctrl.sv
// tel_line_ctrl -- telephone line controller: ring, talk, reject, bill.
// Optional feature macro: TEL_CALL_TIMER_EN adds a per-TICK_CYCLES
// conversation time charge on top of the per-character charges.
module tel_line_ctrl
  import tel_pkg::*;
#(
  parameter int MSG_CHARS     = 8,
  parameter int RING_CYCLES   = 10,
  parameter int REJECT_CYCLES = 10,
  parameter int COST_CYCLES   = 5,
  parameter int COST_W        = 32,
  parameter int DIGIT_COST    = 1,
  parameter int OTHER_COST    = 2,
  parameter int TICK_CYCLES   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   startCall,
  input  logic                   answerCall,
  input  logic                   endCallCaller,
  input  logic                   endCallCallee,
  input  logic                   sendCharCaller,
  input  logic                   sendCharCallee,
  input  logic [7:0]             charSent,
  output logic [63:0]            statusMsg,
  output logic [8*MSG_CHARS-1:0] sentMsg,
  output logic                   busy,
  output logic [COST_W-1:0]      cost
);

  localparam logic [2:0] ST_IDLE     = S_IDLE;
  localparam logic [2:0] ST_RINGING  = S_RINGING;
  localparam logic [2:0] ST_CALLER   = S_CALLER;
  localparam logic [2:0] ST_CALLEE   = S_CALLEE;
  localparam logic [2:0] ST_REJECTED = S_REJECTED;
  localparam logic [2:0] ST_COST     = S_COST;

  localparam int CNT_MAX0 = (RING_CYCLES > REJECT_CYCLES) ? RING_CYCLES : REJECT_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > COST_CYCLES) ? CNT_MAX0 : COST_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int SUM_W    = COST_W + 2;

  localparam logic [8*MSG_CHARS-1:0] SPACES = {MSG_CHARS{ASC_SPACE}};

  logic [2:0]             r_state;
  logic [2:0]             w_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [8*MSG_CHARS-1:0] r_msg;
  logic [8*MSG_CHARS-1:0] w_msg_shift;
  logic [8*MSG_CHARS-1:0] w_msg_hex;
  logic [COST_W-1:0]      r_cost;
  logic [COST_W-1:0]      w_cost_nxt;
  logic [SUM_W-1:0]       w_charge;
  logic [SUM_W-1:0]       w_sum;
  logic                   w_in_conv;
  logic                   w_end;
  logic                   w_honour;
  logic                   w_print;
  logic                   w_del;
  logic                   w_digit;
  logic                   w_tick;

  assign w_in_conv = (r_state == ST_CALLER) || (r_state == ST_CALLEE);
  assign w_end     = endCallCaller || endCallCallee;
  // Only the party that currently owns the line may type.
  assign w_honour  = ((r_state == ST_CALLER) && sendCharCaller) ||
                     ((r_state == ST_CALLEE) && sendCharCallee);
  assign w_print   = (charSent >= ASC_SPACE) && (charSent <= ASC_TILDE);
  assign w_del     = (charSent == ASC_DEL);
  assign w_digit   = (charSent >= ASC_0) && (charSent <= ASC_9);

  // Per-character charge; control characters and DEL are free.
  assign w_charge = !(w_honour && w_print) ? '0 :
                    w_digit ? SUM_W'(DIGIT_COST) : SUM_W'(OTHER_COST);

  // Two guard bits catch overflow of charge + tick; clamp to all-ones.
  assign w_sum      = {2'b00, r_cost} + w_charge + SUM_W'(w_tick);
  assign w_cost_nxt = (w_sum[SUM_W-1:COST_W] != 2'b00) ? '1 : w_sum[COST_W-1:0];

  if (MSG_CHARS == 1) begin : g_shift1
    assign w_msg_shift = charSent;
  end else begin : g_shiftn
    assign w_msg_shift = {r_msg[8*MSG_CHARS-9:0], charSent};
  end

`ifdef TEL_CALL_TIMER_EN
  localparam int TICK_W = $clog2(TICK_CYCLES + 1);
  logic [TICK_W-1:0] r_tick;

  assign w_tick = w_in_conv && (r_tick == TICK_W'(TICK_CYCLES - 1));

  // Conversation timer; survives a CALLER<->CALLEE swap, restarts otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_tick <= '0;
    else if (!w_in_conv) r_tick <= '0;
    else if (w_tick)     r_tick <= '0;
    else                 r_tick <= r_tick + TICK_W'(1);
  end
`else
  logic w_unused_tick;
  assign w_unused_tick = (TICK_CYCLES > 0);
  assign w_tick        = 1'b0;
`endif

  tel_hex_fmt #(
    .COST_W    (COST_W),
    .MSG_CHARS (MSG_CHARS)
  ) u_hex (
    .i_cost (r_cost),
    .o_text (w_msg_hex)
  );

  // Next-state decode with the RINGING priority order and timed exits.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (startCall) w_nxt = ST_RINGING;
      ST_RINGING: begin
        if (endCallCallee)                              w_nxt = ST_REJECTED;
        else if (endCallCaller)                         w_nxt = ST_IDLE;
        else if (answerCall)                            w_nxt = ST_CALLER;
        else if (r_cnt == CNT_W'(RING_CYCLES - 1))      w_nxt = ST_IDLE;
      end
      ST_CALLER: begin
        if (w_end)                                      w_nxt = ST_COST;
        else if (w_honour && w_del)                     w_nxt = ST_CALLEE;
      end
      ST_CALLEE: begin
        if (w_end)                                      w_nxt = ST_COST;
        else if (w_honour && w_del)                     w_nxt = ST_CALLER;
      end
      ST_REJECTED: if (r_cnt == CNT_W'(REJECT_CYCLES - 1)) w_nxt = ST_IDLE;
      ST_COST:     if (r_cnt == CNT_W'(COST_CYCLES - 1))   w_nxt = ST_IDLE;
      default:     w_nxt = ST_IDLE;
    endcase
  end

  // State register and per-state cycle counter, cleared on every change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= (w_nxt != r_state) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Message text and cost accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cost <= '0;
      r_msg  <= SPACES;
    end else if (w_nxt == ST_IDLE) begin
      r_cost <= '0;
      r_msg  <= SPACES;
    end else if (w_nxt == ST_COST && r_state != ST_COST) begin
      r_msg  <= w_msg_hex;
    end else if (w_in_conv && !w_end) begin
      r_cost <= w_cost_nxt;
      if (w_honour && w_del)        r_msg <= SPACES;
      else if (w_honour && w_print) r_msg <= w_msg_shift;
    end
  end

  // Status text decoded straight from the state register.
  always_comb begin
    statusMsg = STR_IDLE;
    case (r_state)
      ST_RINGING:  statusMsg = STR_RINGING;
      ST_CALLER:   statusMsg = STR_CALLER;
      ST_CALLEE:   statusMsg = STR_CALLEE;
      ST_REJECTED: statusMsg = STR_REJECTED;
      ST_COST:     statusMsg = STR_COST;
      default:     statusMsg = STR_IDLE;
    endcase
  end

  assign busy    = (r_state != ST_IDLE);
  assign sentMsg = r_msg;
  assign cost    = r_cost;

endmodule

// File: tb/tb_tel_line_ctrl.sv
// tb_tel_line_ctrl -- directed bench for tel_line_ctrl.
// Three instances share stimulus: defaults, MSG_CHARS=4, COST_W=8.
module tb_tel_line_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        startCall, answerCall, endCallCaller, endCallCallee;
  logic        sendCharCaller, sendCharCallee;
  logic [7:0]  charSent;

  logic [63:0] st_a, msg_a;
  logic        busy_a;
  logic [31:0] cost_a;

  logic [63:0] unused_st_b;
  logic [31:0] msg_b;
  logic        unused_busy_b;
  logic [31:0] unused_cost_b;

  logic [63:0] unused_st_c;
  logic [63:0] msg_c;
  logic        unused_busy_c;
  logic [7:0]  cost_c;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tel_line_ctrl dut_a (
    .clk(clk), .rst(rst), .startCall(startCall), .answerCall(answerCall),
    .endCallCaller(endCallCaller), .endCallCallee(endCallCallee),
    .sendCharCaller(sendCharCaller), .sendCharCallee(sendCharCallee),
    .charSent(charSent), .statusMsg(st_a), .sentMsg(msg_a), .busy(busy_a), .cost(cost_a)
  );

  tel_line_ctrl #(.MSG_CHARS(4)) dut_b (
    .clk(clk), .rst(rst), .startCall(startCall), .answerCall(answerCall),
    .endCallCaller(endCallCaller), .endCallCallee(endCallCallee),
    .sendCharCaller(sendCharCaller), .sendCharCallee(sendCharCallee),
    .charSent(charSent), .statusMsg(unused_st_b), .sentMsg(msg_b), .busy(unused_busy_b),
    .cost(unused_cost_b)
  );

  tel_line_ctrl #(.COST_W(8)) dut_c (
    .clk(clk), .rst(rst), .startCall(startCall), .answerCall(answerCall),
    .endCallCaller(endCallCaller), .endCallCallee(endCallCallee),
    .sendCharCaller(sendCharCaller), .sendCharCallee(sendCharCallee),
    .charSent(charSent), .statusMsg(unused_st_c), .sentMsg(msg_c), .busy(unused_busy_c),
    .cost(cost_c)
  );

  typedef struct {
    logic        s, a, ec, ee, sc, se;
    logic [7:0]  ch;
    logic [63:0] st;
    logic [63:0] msg;
    logic [31:0] cost;
    logic        busy;
  } vec_t;

  vec_t v[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, a, ec, ee, sc, se, input logic [7:0] ch);
    startCall = s; answerCall = a; endCallCaller = ec; endCallCallee = ee;
    sendCharCaller = sc; sendCharCallee = se; charSent = ch;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Hold inputs idle through the remaining COST cycles, then expect IDLE.
  task automatic finish_cost(input string tag);
    idle_in();
    repeat (4) begin
      cyc();
      chk({tag, "_cost_hold"}, st_a, "COST    ");
    end
    cyc();
    chk({tag, "_idle"}, st_a, "IDLE    ");
  endtask

  initial begin
    logic [39:0] s5;
    logic [7:0]  exp_fe;

    rst = 1'b1;
    idle_in();
    #12;
    chk("rst_state", st_a, "IDLE    ");
    chk("rst_busy", {63'd0, busy_a}, 64'd0);
    chk("rst_cost", {32'd0, cost_a}, 64'd0);
    chk("rst_msg", msg_a, "        ");
    rst = 1'b0;

    // Test 1: unanswered ring times out after exactly 10 cycles.
    drive(1, 0, 0, 0, 0, 0, 8'h00);
    cyc();
    idle_in();
    chk("ring_0", st_a, "RINGING ");
    for (int i = 1; i < 10; i++) begin
      cyc();
      chk($sformatf("ring_%0d", i), st_a, "RINGING ");
    end
    cyc();
    chk("ring_timeout", st_a, "IDLE    ");
    chk("ring_busy", {63'd0, busy_a}, 64'd0);

    // Test 2: table-driven conversation.
    v[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "RINGING ", "        ", 32'd0, 1'b1};
    v[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "CALLER  ", "        ", 32'd0, 1'b1};
    v[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h48, "CALLER  ", "       H", 32'd2, 1'b1};
    v[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h35, "CALLER  ", "      H5", 32'd3, 1'b1};
    v[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h51, "CALLER  ", "      H5", 32'd3, 1'b1};
    v[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h7F, "CALLEE  ", "        ", 32'd3, 1'b1};
    v[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41, "CALLEE  ", "       A", 32'd5, 1'b1};
    v[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h42, "CALLEE  ", "       A", 32'd5, 1'b1};
    v[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, "CALLEE  ", "       A", 32'd5, 1'b1};
    v[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "COST    ", "00000005", 32'd5, 1'b1};
    for (int i = 0; i < 10; i++) begin
      drive(v[i].s, v[i].a, v[i].ec, v[i].ee, v[i].sc, v[i].se, v[i].ch);
      cyc();
      chk($sformatf("vec%0d_st", i), st_a, v[i].st);
      chk($sformatf("vec%0d_msg", i), msg_a, v[i].msg);
      chk($sformatf("vec%0d_cost", i), {32'd0, cost_a}, {32'd0, v[i].cost});
      chk($sformatf("vec%0d_busy", i), {63'd0, busy_a}, {63'd0, v[i].busy});
    end
    finish_cost("t2");
    chk("t2_cost_clear", {32'd0, cost_a}, 64'd0);
    chk("t2_msg_clear", msg_a, "        ");

    // RINGING priority: caller hangs up; callee wins over answer.
    drive(1, 0, 0, 0, 0, 0, 8'h00); cyc();
    drive(0, 0, 1, 0, 0, 0, 8'h00); cyc();
    chk("ring_caller_end", st_a, "IDLE    ");
    drive(1, 0, 0, 0, 0, 0, 8'h00); cyc();
    drive(0, 1, 0, 1, 0, 0, 8'h00); cyc();
    chk("ring_reject_prio", st_a, "REJECTED");
    idle_in();
    repeat (9) cyc();
    chk("reject_last", st_a, "REJECTED");
    cyc();
    chk("reject_idle", st_a, "IDLE    ");

    // Test 3: short message window keeps the newest four characters.
    s5 = "ABCDE";
    drive(1, 0, 0, 0, 0, 0, 8'h00); cyc();
    drive(0, 1, 0, 0, 0, 0, 8'h00); cyc();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, 1, 0, s5[8*(4-k) +: 8]);
      cyc();
    end
    chk("t3_msg4", {32'd0, msg_b}, {32'd0, "BCDE"});
    chk("t3_msg8", msg_a, "   ABCDE");
    chk("t3_cost", {32'd0, cost_a}, 64'd10);
    drive(0, 0, 1, 0, 0, 0, 8'h00); cyc();
    chk("t3_cost_st", st_a, "COST    ");
    chk("t3_hex8", msg_a, "0000000A");
    chk("t3_hex4", {32'd0, msg_b}, {32'd0, "000A"});
    chk("t3_hex_w8", msg_c, "      0A");
    finish_cost("t3");

    // Test 4: 8-bit accumulator saturates instead of wrapping.
`ifdef TEL_CALL_TIMER_EN
    exp_fe = 8'hFF;
`else
    exp_fe = 8'hFE;
`endif
    drive(1, 0, 0, 0, 0, 0, 8'h00); cyc();
    drive(0, 1, 0, 0, 0, 0, 8'h00); cyc();
    drive(0, 0, 0, 0, 1, 0, 8'h58);
    repeat (127) cyc();
    chk("t4_cost_127", {56'd0, cost_c}, {56'd0, exp_fe});
    cyc();
    chk("t4_cost_128", {56'd0, cost_c}, 64'hFF);
    repeat (2) cyc();
    chk("t4_cost_130", {56'd0, cost_c}, 64'hFF);
    drive(0, 0, 1, 0, 0, 0, 8'h00); cyc();
    chk("t4_hex", msg_c, "      FF");
    finish_cost("t4");

    // Test 5: hang-up beats a same-cycle character.
    drive(1, 0, 0, 0, 0, 0, 8'h00); cyc();
    drive(0, 1, 0, 0, 0, 0, 8'h00); cyc();
    drive(0, 0, 1, 0, 1, 0, 8'h5A); cyc();
    chk("t5_st", st_a, "COST    ");
    chk("t5_cost", {32'd0, cost_a}, 64'd0);
    chk("t5_hex", msg_a, "00000000");
    finish_cost("t5");

    // Test 6: asynchronous reset in the middle of a CALLEE turn.
    drive(1, 0, 0, 0, 0, 0, 8'h00); cyc();
    drive(0, 1, 0, 0, 0, 0, 8'h00); cyc();
    drive(0, 0, 0, 0, 1, 0, 8'h37); cyc();
    drive(0, 0, 0, 0, 1, 0, 8'h7F); cyc();
    idle_in();
    chk("t6_callee", st_a, "CALLEE  ");
    chk("t6_cost_pre", {32'd0, cost_a}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_st", st_a, "IDLE    ");
    chk("t6_rst_cost", {32'd0, cost_a}, 64'd0);
    chk("t6_rst_msg", msg_a, "        ");
    chk("t6_rst_busy", {63'd0, busy_a}, 64'd0);
    #1 rst = 1'b0;

    // Idle conversation: only the optional timer can charge.
    drive(1, 0, 0, 0, 0, 0, 8'h00); cyc();
    drive(0, 1, 0, 0, 0, 0, 8'h00); cyc();
    idle_in();
    repeat (32) cyc();
    chk("t6_conv_st", st_a, "CALLER  ");
`ifdef TEL_CALL_TIMER_EN
    chk("t6_timer_cost", {32'd0, cost_a}, 64'd2);
`else
    chk("t6_timer_cost", {32'd0, cost_a}, 64'd0);
`endif
    drive(0, 0, 1, 0, 0, 0, 8'h00); cyc();
    finish_cost("t6");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/tel_line_ctrl.md
TEL_LINE_CTRL -- requirements
Module: tel_line_ctrl

Interface
REQ-001 SHALL have parameter MSG_CHARS, default 8, meaning sent_msg length in ASCII characters (>=1).
REQ-002 SHALL have parameter RING_CYCLES, default 10, meaning cycles in RINGING before unanswered timeout.
REQ-003 SHALL have parameter REJECT_CYCLES, default 10, meaning cycles REJECTED is held.
REQ-004 SHALL have parameter COST_CYCLES, default 5, meaning cycles COST is held.
REQ-005 SHALL have parameter COST_W, default 32, meaning cost accumulator width (multiple of 4).
REQ-006 SHALL have parameter DIGIT_COST, default 1, and OTHER_COST, default 2, meaning per-character charges.
REQ-007 SHALL have parameter TICK_CYCLES, default 16, meaning conversation cycles per timer charge.
REQ-008 SHALL have ports: clk in 1 clock; rst in 1 reset; one clock; reset is asynchronous and active-high.
REQ-009 SHALL have ports: startCall, answerCall, endCallCaller, endCallCallee, sendCharCaller, sendCharCallee, all in 1, level-sampled at posedge clk.
REQ-010 SHALL have port charSent in 8, the ASCII character offered by the sending party.
REQ-011 SHALL have port statusMsg out 64, eight ASCII state-name characters, first character in [63:56].
REQ-012 SHALL have port sentMsg out 8*MSG_CHARS, message or cost text, newest/least-significant character in [7:0].
REQ-013 SHALL have ports busy out 1, high in any state other than IDLE, and cost out COST_W, the live accumulator.

Function
REQ-014 SHALL implement states IDLE, RINGING, CALLER, CALLEE, REJECTED, COST, with a per-state cycle counter that clears on every state change.
REQ-015 IDLE SHALL go to RINGING on startCall.
REQ-016 RINGING priority SHALL be: endCallCallee -> REJECTED; endCallCaller -> IDLE; answerCall -> CALLER; otherwise -> IDLE after exactly RING_CYCLES cycles in RINGING.
REQ-017 CALLER/CALLEE SHALL go to COST on endCallCaller or endCallCallee, taking priority over any character in the same cycle.
REQ-018 In CALLER, only sendCharCaller is honoured; in CALLEE, only sendCharCallee; the other party's strobe SHALL be ignored and not charged.
REQ-019 An honoured charSent in 32..126 SHALL shift sentMsg left one character and insert it at [7:0]; the oldest character is dropped.
REQ-020 An honoured charSent of 127 SHALL clear sentMsg to spaces, swap CALLER<->CALLEE, and cost nothing.
REQ-021 Other honoured values (0..31, 128..255) SHALL be ignored and not charged.
REQ-022 Charges: digits 48..57 add DIGIT_COST; other printable characters add OTHER_COST; the sum SHALL saturate at all-ones, never wrap.
REQ-023 REJECTED SHALL return to IDLE after REJECT_CYCLES cycles; COST after COST_CYCLES cycles; inputs are ignored in both.
REQ-024 On entering COST, sentMsg SHALL show cost as uppercase hex, right-aligned; characters beyond COST_W/4 digits are spaces; if MSG_CHARS < COST_W/4, only the low digits are shown.
REQ-025 statusMsg SHALL be a combinational decode of the state register: "IDLE    ", "RINGING ", "CALLER  ", "CALLEE  ", "REJECTED", "COST    ".
REQ-026 Entering IDLE SHALL clear cost to 0 and sentMsg to spaces.
REQ-027 Registered outputs SHALL update one cycle after the sampling edge.

Reset
REQ-028 rst SHALL force state IDLE, counter 0, cost 0, sentMsg all spaces, and busy 0 immediately, at any point including mid-call.

Configuration
REQ-029 With TEL_CALL_TIMER_EN defined, CALLER/CALLEE SHALL add 1 to cost every TICK_CYCLES consecutive conversation cycles; the tick counter is not cleared on a CALLER<->CALLEE swap.
REQ-030 A tick and a character charge in the same cycle SHALL both be added, with saturation.
REQ-031 Without TEL_CALL_TIMER_EN, there SHALL be no tick logic, and cost is per-character only.

Structure
REQ-032 The package tel_pkg SHALL hold the state enum, ASCII constants (space, DEL, '0', '9', 'A'), and the six 64-bit status strings.
REQ-033 Hex formatting SHALL be in sub-module tel_hex_fmt (combinational, parametrised by COST_W and MSG_CHARS).

Verification
REQ-034 Test 1: startCall, no answer, defaults -> statusMsg "RINGING " for 10 cycles, then "IDLE    ", and busy falls.
REQ-035 Test 2: startCall, answerCall, caller sends 'H','5',DEL, callee sends 'A', then endCallCallee -> cost 5, and sentMsg ends "00000005" during COST for 5 cycles.
REQ-036 Test 3: with MSG_CHARS=4, send "ABCDE" -> sentMsg="BCDE".
REQ-037 Test 4: COST_W=8 preloaded near 0xFF via 130 'X' characters -> cost holds 0xFF and does not wrap.
REQ-038 Test 5: endCallCallee in RINGING -> "REJECTED" for 10 cycles; in CALLER, endCallCaller together with sendCharCaller 'Z' -> COST, with 'Z' not charged.
REQ-039 Test 6: rst asserted mid-CALLEE -> IDLE, spaces, and cost 0 asynchronously; with TEL_CALL_TIMER_EN, 32 idle conversation cycles -> cost 2.
